// File: rtl/inst_buffer.sv
// N-wide circular instruction buffer between Fetch and Dispatch.
// Occupancy, free space and head entries are driven from registered state only.
module inst_buffer #(
    parameter int N     = 3,
    parameter int DEPTH = 8,
    parameter int PKT_W = 64,
    parameter int CNT_W = $clog2(N + 1),
    parameter int OCC_W = $clog2(DEPTH + 1)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [N*PKT_W-1:0] inst_buffer_inputs,
    input  logic [CNT_W-1:0]   instructions_valid,
    output logic [CNT_W-1:0]   inst_buffer_spots,
    input  logic               flush,
    input  logic [CNT_W-1:0]   dispatch_spots,
    output logic [N*PKT_W-1:0] inst_buffer_outputs,
    output logic [CNT_W-1:0]   outputs_valid
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [OCC_W-1:0] DEPTH_O = OCC_W'(DEPTH);
    localparam logic [OCC_W-1:0] N_O     = OCC_W'(N);
    localparam logic [CNT_W-1:0] N_C     = CNT_W'(N);

    logic [PKT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [OCC_W-1:0] count;
    logic [OCC_W-1:0] free;
    logic [CNT_W-1:0] enq;
    logic [CNT_W-1:0] deq;

    // Handshake: Fetch may offer at most inst_buffer_spots packets (lanes 0..k-1);
    // Dispatch takes min(dispatch_spots, outputs_valid) from lane 0 upward.
    // Free space is taken before the same-cycle dequeue, so a full buffer
    // advertises zero even while it drains.
    always_comb begin
        free              = DEPTH_O - count;
        inst_buffer_spots = (free >= N_O) ? N_C : free[CNT_W-1:0];
        outputs_valid     = (count >= N_O) ? N_C : count[CNT_W-1:0];
        enq = (instructions_valid < inst_buffer_spots) ? instructions_valid : inst_buffer_spots;
        deq = (dispatch_spots < outputs_valid) ? dispatch_spots : outputs_valid;
    end

    always_comb begin
        inst_buffer_outputs = '0;
        for (int i = 0; i < N; i++) begin
            if (CNT_W'(i) < outputs_valid)
                inst_buffer_outputs[i*PKT_W +: PKT_W] = mem[head + PTR_W'(i)];
        end
    end

    // Entry storage carries no reset; only pointers and count define contents.
    always_ff @(posedge clock) begin
        if (!reset && !flush) begin
            for (int j = 0; j < N; j++) begin
                if (CNT_W'(j) < enq)
                    mem[tail + PTR_W'(j)] <= inst_buffer_inputs[j*PKT_W +: PKT_W];
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset || flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq);
            tail  <= tail + PTR_W'(enq);
            count <= count + OCC_W'(enq) - OCC_W'(deq);
        end
    end

`ifndef SYNTHESIS
    a_fetch_overrun: assert property (@(posedge clock) disable iff (reset || flush)
        instructions_valid <= inst_buffer_spots)
        else $error("inst_buffer: Fetch sent more packets than advertised spots");
    a_count_max: assert property (@(posedge clock) disable iff (reset)
        count <= DEPTH_O)
        else $error("inst_buffer: occupancy above DEPTH");
    a_count_min: assert property (@(posedge clock) disable iff (reset)
        OCC_W'(deq) <= count)
        else $error("inst_buffer: dequeue larger than occupancy");
`endif

endmodule

// File: tb/tb_inst_buffer.sv
// Directed vector table plus queue-model scoreboard for inst_buffer.
module tb_inst_buffer;
    localparam int N     = 3;
    localparam int DEPTH = 8;
    localparam int PKT_W = 64;
    localparam int CNT_W = 2;

    logic               clock = 1'b0;
    logic               reset = 1'b1;
    logic               flush = 1'b0;
    logic [N*PKT_W-1:0] inst_buffer_inputs = '0;
    logic [CNT_W-1:0]   instructions_valid = '0;
    logic [CNT_W-1:0]   inst_buffer_spots;
    logic [CNT_W-1:0]   dispatch_spots = '0;
    logic [N*PKT_W-1:0] inst_buffer_outputs;
    logic [CNT_W-1:0]   outputs_valid;

    inst_buffer #(.N(N), .DEPTH(DEPTH), .PKT_W(PKT_W)) dut (
        .clock               (clock),
        .reset               (reset),
        .inst_buffer_inputs  (inst_buffer_inputs),
        .instructions_valid  (instructions_valid),
        .inst_buffer_spots   (inst_buffer_spots),
        .flush               (flush),
        .dispatch_spots      (dispatch_spots),
        .inst_buffer_outputs (inst_buffer_outputs),
        .outputs_valid       (outputs_valid)
    );

    // clock / reset
    always #5 clock = ~clock;

    int tests = 0;
    int fails = 0;
    logic [PKT_W-1:0] exp_q[$];
    logic [31:0]      disp_q[$];
    logic [31:0]      next_pc = 32'h0;

    typedef struct {
        int          iv;
        int          ds;
        bit          fl;
        int          exp_spots;
        int          exp_ov;
        logic [31:0] exp_pc;
    } vec_t;
    vec_t vecs[18];

    function automatic int imin(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    function automatic logic [PKT_W-1:0] mk(input logic [31:0] pc);
        return {pc ^ 32'hC0DE_0000, pc};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // scoreboard: compare DUT view against the queue model
    task automatic model_check();
        int sp;
        int ov;
        sp = imin(DEPTH - exp_q.size(), N);
        ov = imin(exp_q.size(), N);
        check("spots", 64'(inst_buffer_spots), 64'(sp));
        check("outputs_valid", 64'(outputs_valid), 64'(ov));
        for (int i = 0; i < N; i++)
            check($sformatf("lane%0d", i), inst_buffer_outputs[i*PKT_W +: PKT_W],
                  (i < ov) ? exp_q[i] : 64'h0);
    endtask

    // driver: called at a negedge, returns at the next negedge
    task automatic do_cycle(input int iv, input int ds, input bit fl);
        int sp;
        int ov;
        int deq;
        model_check();
        sp  = imin(DEPTH - exp_q.size(), N);
        ov  = imin(exp_q.size(), N);
        deq = imin(ds, ov);
        if (!fl)
            for (int i = 0; i < deq; i++)
                disp_q.push_back(inst_buffer_outputs[i*PKT_W +: 32]);
        instructions_valid = CNT_W'(iv);
        dispatch_spots     = CNT_W'(ds);
        flush              = fl;
        for (int j = 0; j < N; j++)
            inst_buffer_inputs[j*PKT_W +: PKT_W] = (j < iv) ? mk(next_pc + 32'(4 * j))
                                                             : {$urandom, $urandom};
        @(posedge clock);
        if (fl) begin
            exp_q.delete();
            next_pc = (next_pc + 32'h400) & ~32'h3FF;
        end else begin
            for (int i = 0; i < deq; i++) void'(exp_q.pop_front());
            for (int j = 0; j < imin(iv, sp); j++) exp_q.push_back(mk(next_pc + 32'(4 * j)));
            next_pc = next_pc + 32'(4 * imin(iv, sp));
        end
        @(negedge clock);
    endtask

    initial begin
        // fill, simultaneous full drain/refill, flush, then partial alternation
        vecs[0]  = '{3, 0, 0, 3, 0, 32'h0};
        vecs[1]  = '{3, 0, 0, 3, 3, 32'h0};
        vecs[2]  = '{2, 0, 0, 2, 3, 32'h0};
        vecs[3]  = '{0, 0, 0, 0, 3, 32'h0};
        vecs[4]  = '{0, 3, 0, 0, 3, 32'h0};
        vecs[5]  = '{3, 0, 0, 3, 3, 32'hC};
        vecs[6]  = '{0, 3, 0, 0, 3, 32'hC};
        vecs[7]  = '{0, 1, 0, 3, 3, 32'h18};
        vecs[8]  = '{2, 0, 0, 3, 3, 32'h1C};
        vecs[9]  = '{2, 2, 1, 2, 3, 32'h1C};
        vecs[10] = '{3, 0, 0, 3, 0, 32'h0};
        vecs[11] = '{0, 3, 0, 3, 3, 32'h400};
        vecs[12] = '{0, 0, 0, 3, 0, 32'h0};
        vecs[13] = '{1, 2, 0, 3, 0, 32'h0};
        vecs[14] = '{2, 0, 0, 3, 1, 32'h40C};
        vecs[15] = '{1, 2, 0, 3, 3, 32'h40C};
        vecs[16] = '{2, 0, 0, 3, 2, 32'h414};
        vecs[17] = '{0, 3, 0, 3, 3, 32'h414};

        // reset held for five cycles
        repeat (5) begin
            @(negedge clock);
            check("rst_spots", 64'(inst_buffer_spots), 64'd3);
            check("rst_ovalid", 64'(outputs_valid), 64'd0);
            check("rst_outputs", 64'(|inst_buffer_outputs), 64'd0);
        end
        reset = 1'b0;

        foreach (vecs[k]) begin
            check($sformatf("tbl%0d_spots", k), 64'(inst_buffer_spots), 64'(vecs[k].exp_spots));
            check($sformatf("tbl%0d_ovalid", k), 64'(outputs_valid), 64'(vecs[k].exp_ov));
            check($sformatf("tbl%0d_lane0", k), inst_buffer_outputs[0 +: PKT_W],
                  (vecs[k].exp_ov != 0) ? mk(vecs[k].exp_pc) : 64'h0);
            do_cycle(vecs[k].iv, vecs[k].ds, vecs[k].fl);
        end

        // drain, then stream at full width long enough to wrap several times
        for (int g = 0; g < 10 && exp_q.size() > 0; g++) do_cycle(0, 3, 0);
        check("drained", 64'(exp_q.size()), 64'd0);
        disp_q.delete();
        for (int c = 0; c < 20; c++) begin
            do_cycle(imin(DEPTH - exp_q.size(), N), 3, 0);
            check("stream_ovalid", 64'(outputs_valid), 64'd3);
        end
        check("stream_count", 64'(disp_q.size()), 64'd57);
        for (int k = 1; k < disp_q.size(); k++)
            check("stream_seq", 64'(disp_q[k]), 64'(disp_q[k-1] + 32'd4));

        // reset from a non-empty state
        do_cycle(3, 0, 0);
        reset = 1'b1;
        instructions_valid = 2'd3;
        dispatch_spots = 2'd3;
        @(posedge clock);
        exp_q.delete();
        @(negedge clock);
        check("midrst_spots", 64'(inst_buffer_spots), 64'd3);
        check("midrst_ovalid", 64'(outputs_valid), 64'd0);
        check("midrst_outputs", 64'(|inst_buffer_outputs), 64'd0);
        reset = 1'b0;

        // random legal traffic against the model
        for (int c = 0; c < 300; c++)
            do_cycle($urandom_range(0, imin(DEPTH - exp_q.size(), N)),
                     $urandom_range(0, 3), ($urandom_range(0, 19) == 0));
        model_check();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
